seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner.
// Time-slices a common set of segment lines across DIGITS digits. Each slot
// lasts DIV clocks and starts with BLANK dark clocks to prevent ghosting.
// Digits masked off in digit_en are skipped without leaving a dead slot.
// All display outputs are registered.
module seven_seg_scan_ctrl #(
    parameter  int DIGITS = 4,
    parameter  int DIV    = 24000,
    parameter  int BLANK  = 240,
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [DIGITS-1:0]     sel_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_start
);

    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);

    // Segment patterns, active-low, ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt;
    logic             started;     // low until the first slot has been opened after reset
    logic [3:0]       code_q;      // hex code captured for the current owner
    logic             dp_q;        // decimal point captured for the current owner

    logic             any_en;
    logic             cur_en;
    logic             above_found;
    logic [IDX_W-1:0] low_idx;
    logic [IDX_W-1:0] above_idx;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] slot_idx;
    logic             slot_start;
    logic [3:0]       slot_code;
    logic             slot_dp;

    // Pick the owner of the next slot and fetch the data it will display.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
        any_en      = |digit_en;
        cur_en      = 1'b0;
        above_found = 1'b0;
        low_idx     = '0;
        above_idx   = '0;
        // Walking downwards leaves the lowest qualifying index in place.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (IDX_W'(i) == scan_idx) begin
                cur_en = digit_en[i];
            end
            if (digit_en[i]) begin
                low_idx = IDX_W'(i);
                if (i > int'(scan_idx)) begin
                    above_idx   = IDX_W'(i);
                    above_found = 1'b1;
                end
            end
        end

        if (above_found) begin
            next_idx = above_idx;
        end else if (any_en) begin
            next_idx = low_idx;
        end else begin
            next_idx = scan_idx;
        end

        // The very first slot after reset goes straight to the lowest enabled digit.
        if (started) begin
            slot_idx = next_idx;
        end else begin
            slot_idx = any_en ? low_idx : scan_idx;
        end
        slot_start = !started || (cnt == CNT_LAST);

        slot_code = '0;
        slot_dp   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == slot_idx) begin
                slot_code = digit_data[4*i +: 4];
                slot_dp   = dp_in[i];
            end
        end
    end

    // Slot timing, owner advance, data capture and frame marker.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            started     <= 1'b0;
            cnt         <= '0;
            scan_idx    <= '0;
            code_q      <= '0;
            dp_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            started <= 1'b1;
            if (slot_start) begin
                cnt         <= '0;
                scan_idx    <= slot_idx;
                code_q      <= slot_code;
                dp_q        <= slot_dp;
                frame_start <= any_en && (slot_idx == low_idx);
            end else begin
                cnt         <= cnt + CNT_W'(1);
                frame_start <= 1'b0;
            end
        end
    end

    // Drive the display from this cycle's slot position, owner and captured data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_n <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else if (!started || (cnt < BLANK_C) || !cur_en) begin
            sel_n <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            sel_n <= ~(DIGITS'(1) << scan_idx);
            seg_n <= decode(code_q);
            dp_n  <= ~dp_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (DIGITS=4, DIV=8, BLANK=2).
// A slot-level reference model predicts every registered output each cycle;
// scenario tasks add targeted checks on top of the model comparison.
module tb_seven_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digit_data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  sel_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  scan_idx;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    seven_seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .sel_n      (sel_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .scan_idx   (scan_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Active-low segment table, indexed by hex code.
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- reference model ----------------
    // m_cnt = position inside the current slot, -1 before the first slot after reset.
    int         m_cnt;
    int         m_owner;
    logic [3:0] m_code;
    logic       m_dp;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fs;

    function automatic int lowest_en(input logic [3:0] en);
        for (int i = 0; i < DIGITS; i++) if (en[i]) return i;
        return 0;
    endfunction

    // Circular search for the next enabled digit after cur (cur itself last).
    function automatic int circ_next(input int cur, input logic [3:0] en);
        for (int k = 1; k <= DIGITS; k++) if (en[(cur + k) % DIGITS]) return (cur + k) % DIGITS;
        return cur;
    endfunction

    function automatic int new_owner(input int pos, input int cur, input logic [3:0] en);
        if (en == 4'd0) return cur;
        if (pos < 0) return lowest_en(en);
        return circ_next(cur, en);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= -1;
            m_owner <= 0;
            m_code  <= 4'd0;
            m_dp    <= 1'b0;
            exp_sel <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            exp_fs  <= 1'b0;
        end else begin
            if (m_cnt >= BLANK && digit_en[m_owner]) begin
                exp_sel <= ~(4'b0001 << m_owner);
                exp_seg <= seg_tbl[m_code];
                exp_dp  <= ~m_dp;
            end else begin
                exp_sel <= 4'hF;
                exp_seg <= 7'h7F;
                exp_dp  <= 1'b1;
            end
            if (m_cnt < 0 || m_cnt == DIV - 1) begin
                m_owner <= new_owner(m_cnt, m_owner, digit_en);
                m_code  <= digit_data[4*new_owner(m_cnt, m_owner, digit_en) +: 4];
                m_dp    <= dp_in[new_owner(m_cnt, m_owner, digit_en)];
                exp_fs  <= (digit_en != 4'd0) &&
                           (new_owner(m_cnt, m_owner, digit_en) == lowest_en(digit_en));
                m_cnt   <= 0;
            end else begin
                m_cnt   <= m_cnt + 1;
                exp_fs  <= 1'b0;
            end
        end
    end

    function automatic logic [14:0] obs();
        return {sel_n, seg_n, dp_n, frame_start, scan_idx};
    endfunction

    function automatic logic [14:0] expv();
        return {exp_sel, exp_seg, exp_dp, exp_fs, 2'(m_owner)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst        = 1'b1;
        digit_en   = 4'hF;
        digit_data = 16'h4321;
        dp_in      = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || scan_idx !== 2'd0 || sel_n !== 4'hF) begin
            failures++;
            $display("FAIL reset_first_slot got fs=%b idx=%0d sel=%h exp fs=1 idx=0 sel=f",
                     frame_start, scan_idx, sel_n);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
        end
    endtask

    task automatic test_all_enabled;
        int  low_cnt [4] = '{0, 0, 0, 0};
        logic [6:0] seg_seen [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        int  fs_cnt = 0;
        bit  found  = 0;
        digit_en   = 4'hF;
        digit_data = 16'h4321;
        dp_in      = 4'h0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL all_en_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (frame_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL all_en_frame_wait got no frame_start exp pulse within 64 cycles");
        end else begin
            for (int c = 0; c < 32; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    checks++;
                    if (obs() !== expv()) begin
                        failures++;
                        $display("FAIL all_en_model t=%0t got=%h exp=%h", $time, obs(), expv());
                    end
                end
                if (frame_start === 1'b1) fs_cnt++;
                for (int d = 0; d < 4; d++) begin
                    if (sel_n === ~(4'b0001 << d)) begin
                        low_cnt[d]++;
                        seg_seen[d] = seg_n;
                    end
                end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (low_cnt[d] != 6 || seg_seen[d] !== seg_tbl[d + 1]) begin
                    failures++;
                    $display("FAIL all_en_digit%0d got low=%0d seg=%h exp low=6 seg=%h",
                             d, low_cnt[d], seg_seen[d], seg_tbl[d + 1]);
                end
            end
            checks++;
            if (fs_cnt != 1) begin
                failures++;
                $display("FAIL all_en_frame_count got=%0d exp=1", fs_cnt);
            end
        end
    endtask

    task automatic test_sparse;
        int fs_cnt = 0;
        int lit0   = 0;
        int lit2   = 0;
        bit found  = 0;
        digit_en = 4'b0101;
        for (int c = 0; c < 84 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL sparse_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (c >= 20 && frame_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL sparse_frame_wait got no frame_start exp pulse");
        end else begin
            for (int c = 0; c < 32; c++) begin
                if (c > 0) @(negedge clk);
                if (frame_start === 1'b1) fs_cnt++;
                if (sel_n === 4'hE) lit0++;
                if (sel_n === 4'hB) lit2++;
                checks++;
                if (!(sel_n === 4'hE || sel_n === 4'hB || sel_n === 4'hF)) begin
                    failures++;
                    $display("FAIL sparse_sel got=%h exp=e/b/f", sel_n);
                end
            end
            checks++;
            if (fs_cnt != 2 || lit0 != 12 || lit2 != 12) begin
                failures++;
                $display("FAIL sparse_counts got fs=%0d lit0=%0d lit2=%0d exp fs=2 lit0=12 lit2=12",
                         fs_cnt, lit0, lit2);
            end
        end
    endtask

    task automatic test_idle_then_single;
        logic [1:0] held;
        int fs_cnt = 0;
        int lit3   = 0;
        @(negedge clk);
        held     = scan_idx;
        digit_en = 4'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({sel_n, seg_n, dp_n, frame_start, scan_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, held}) begin
                failures++;
                $display("FAIL idle_outputs got=%h exp=%h", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, held});
            end
        end
        digit_en = 4'b1000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL single_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_cnt++;
            if (sel_n === 4'h7) lit3++;
            checks++;
            if (scan_idx !== 2'd3 || !(sel_n === 4'h7 || sel_n === 4'hF)) begin
                failures++;
                $display("FAIL single_owner got idx=%0d sel=%h exp idx=3 sel=7/f", scan_idx, sel_n);
            end
        end
        checks++;
        if (fs_cnt != 2 || lit3 != 12) begin
            failures++;
            $display("FAIL single_counts got fs=%0d lit=%0d exp fs=2 lit=12", fs_cnt, lit3);
        end
    endtask

    task automatic test_data_hold;
        bit found      = 0;
        bit seen_other = 0;
        int e_before   = 0;
        int e_after    = 0;
        digit_en   = 4'hF;
        digit_data = 16'h4328;
        dp_in      = 4'h0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL hold_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (c >= 36 && m_owner == 0 && m_cnt == 4) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL hold_wait got no digit-0 slot exp one within 80 cycles");
        end else begin
            digit_data = 16'h4321;
            for (int c = 0; c < 44; c++) begin
                @(negedge clk);
                if (sel_n === 4'hD || sel_n === 4'hB || sel_n === 4'h7) seen_other = 1;
                if (sel_n === 4'hE) begin
                    checks++;
                    if (seg_n !== (seen_other ? 7'h79 : 7'h00)) begin
                        failures++;
                        $display("FAIL hold_seg got=%h exp=%h", seg_n, seen_other ? 7'h79 : 7'h00);
                    end
                    if (seen_other) e_after++;
                    else e_before++;
                end
            end
            checks++;
            if (e_before != 4 || e_after != 6) begin
                failures++;
                $display("FAIL hold_counts got before=%0d after=%0d exp before=4 after=6",
                         e_before, e_after);
            end
        end
    endtask

    task automatic test_async_reset;
        bit found = 0;
        digit_en   = 4'hF;
        digit_data = 16'h4321;
        dp_in      = 4'h0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL areset_model t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (m_owner == 2 && m_cnt == 5) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL areset_wait got no idx2 cnt5 exp one within 64 cycles");
        end else begin
            checks++;
            if (sel_n !== 4'hB || seg_n !== 7'h30) begin
                failures++;
                $display("FAIL areset_pre got sel=%h seg=%h exp sel=b seg=30", sel_n, seg_n);
            end
            #1 rst = 1'b1;
            #1;
            checks++;
            if (obs() !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
                failures++;
                $display("FAIL areset_immediate got=%h exp=%h", obs(), {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
            end
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (frame_start !== 1'b1 || scan_idx !== 2'd0) begin
                failures++;
                $display("FAIL areset_restart got fs=%b idx=%0d exp fs=1 idx=0", frame_start, scan_idx);
            end
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL areset_model t=%0t got=%h exp=%h", $time, obs(), expv());
                end
            end
        end
    endtask

    task automatic test_dp_decode;
        digit_en = 4'hF;
        dp_in    = 4'b0010;
        for (int code = 0; code < 16; code++) begin
            digit_data = {4{4'(code)}};
            for (int c = 0; c < 68; c++) begin
                @(negedge clk);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL dp_model code=%h got=%h exp=%h", code, obs(), expv());
                end
                if (c >= 36) begin
                    checks++;
                    if (sel_n === 4'hF) begin
                        if (seg_n !== 7'h7F || dp_n !== 1'b1) begin
                            failures++;
                            $display("FAIL dp_blank code=%h got seg=%h dp=%b exp seg=7f dp=1",
                                     code, seg_n, dp_n);
                        end
                    end else if (seg_n !== seg_tbl[code] || dp_n !== (sel_n === 4'hD ? 1'b0 : 1'b1)) begin
                        failures++;
                        $display("FAIL dp_decode code=%h sel=%h got seg=%h dp=%b exp seg=%h dp=%b",
                                 code, sel_n, seg_n, dp_n, seg_tbl[code], (sel_n === 4'hD) ? 1'b0 : 1'b1);
                    end
                end
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv() || $countones(~sel_n) > 1) begin
                failures++;
                $display("FAIL random_model t=%0t en=%b got=%h exp=%h", $time, digit_en, obs(), expv());
            end
            if ($urandom_range(7) == 0) begin
                digit_data = 16'($urandom);
                dp_in      = 4'($urandom);
            end
            if ($urandom_range(15) == 0) digit_en = 4'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_enabled();
        test_sparse();
        test_idle_then_single();
        test_data_hold();
        test_async_reset();
        test_dp_decode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
